// File: rtl/serial_frame_receiver.sv
// Serial frame deserialiser: start bit, WIDTH data bits MSB-first, optional even parity.
// Completed words sit in a single-entry valid/ready slot; a frame that finds the slot full is dropped.
module serial_frame_receiver #(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             serial_in,
   input  logic             data_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             parity_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      even_parity = ^word;
   endfunction

   logic [1:0]       state_r;
   logic [1:0]       state_s;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_s;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_s;
   logic [WIDTH-1:0] word_s;
   logic             perr_s;
   logic             complete_s;
   logic             slot_free_s;
   logic [WIDTH-1:0] data_out_r;
   logic             data_valid_r;
   logic             parity_err_r;
   logic             overrun_r;
   logic             busy_r;

   // Frame FSM next state; complete_s marks the edge that samples the last bit of a frame
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      shift_s    = shift_r;
      word_s     = shift_r;
      perr_s     = 1'b0;
      complete_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (serial_in) begin
               state_s = ST_DATA;
               cnt_s   = {CW{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            shift_s = {shift_r[WIDTH-2:0], serial_in};
            cnt_s   = cnt_r + CW'(1);
            if (cnt_r == LAST_BIT) begin
               if (PARITY_EN) begin
                  state_s = ST_PARITY;
               end else begin
                  state_s    = ST_IDLE;
                  word_s     = shift_s;
                  complete_s = 1'b1;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            state_s    = ST_IDLE;
            complete_s = 1'b1;
            perr_s     = serial_in ^ even_parity(shift_r);
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = {CW{1'b0}};
         end
      endcase
   end

   // The slot may take a new word if empty or being drained on this very edge
   always_comb begin
      slot_free_s = ~data_valid_r | data_ready;
   end

   // Frame FSM state, bit counter, shift register and busy flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CW{1'b0}};
         shift_r <= {WIDTH{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         shift_r <= shift_s;
         busy_r  <= (state_s != ST_IDLE);
      end
   end

   // Output slot: load on completion if free, else flag overrun; clear on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_r   <= {WIDTH{1'b0}};
         data_valid_r <= 1'b0;
         parity_err_r <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         overrun_r <= 1'b0;
         if (complete_s && slot_free_s) begin
            data_out_r   <= word_s;
            parity_err_r <= perr_s;
            data_valid_r <= 1'b1;
         end else if (complete_s) begin
            overrun_r <= 1'b1;
         end else if (data_valid_r && data_ready) begin
            data_valid_r <= 1'b0;
         end else begin
            data_valid_r <= data_valid_r;
         end
      end
   end

   assign data_out   = data_out_r;
   assign data_valid = data_valid_r;
   assign parity_err = parity_err_r;
   assign overrun    = overrun_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench: the sender describes each frame's completion; a slot model
// queues expected words and a negedge monitor compares every accepted word.
module tb_serial_frame_receiver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       serial_p, data_ready;
   logic [3:0] data_out;
   logic       data_valid, parity_err, overrun, busy;
   logic       serial_n, ready_n;
   logic [3:0] data_out_n;
   logic       valid_n, perr_n, overrun_n, busy_n;

   int checks = 0;
   int errors = 0;

   // sender's description of what the upcoming edge completes
   logic       cur_comp;
   logic [3:0] cur_w;
   logic       cur_pe;

   logic [4:0] exp_q[$];
   logic       m_valid, m_ovr;
   logic       mon_en = 1'b0;

   always #5 clk = ~clk;

   serial_frame_receiver #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .serial_in(serial_p), .data_ready(data_ready),
      .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
      .overrun(overrun), .busy(busy));

   serial_frame_receiver #(.WIDTH(4), .PARITY_EN(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .serial_in(serial_n), .data_ready(ready_n),
      .data_out(data_out_n), .data_valid(valid_n), .parity_err(perr_n),
      .overrun(overrun_n), .busy(busy_n));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Single-entry output slot model fed by frame completions
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         exp_q.delete();
      end else begin
         m_ovr = 1'b0;
         if (cur_comp) begin
            if (!m_valid || data_ready) begin
               exp_q.push_back({cur_pe, cur_w});
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && data_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Monitor: per-cycle flags, and the queued word on every handshake
   always @(negedge clk) begin
      logic [4:0] e;
      if (rst_n && mon_en) begin
         chk("data_valid", int'(data_valid), int'(m_valid));
         chk("overrun", int'(overrun), int'(m_ovr));
         if (data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("data_out", int'(data_out), int'(e[3:0]));
               chk("parity_err", int'(parity_err), int'(e[4]));
            end
         end
      end
   end

   task automatic drive(input logic s, input logic r, input logic comp,
                        input logic [3:0] w, input logic pe);
      serial_p   = s;
      data_ready = r;
      cur_comp   = comp;
      cur_w      = w;
      cur_pe     = pe;
      @(posedge clk);
      #1;
   endtask

   // mode: 0 ready low, 1 ready high, 2 random, 3 ready only on the completing edge
   task automatic send_frame(input logic [3:0] w, input logic pbit, input int mode,
                             output int busy_cnt);
      logic r;
      busy_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         case (mode)
            0: r = 1'b0;
            1: r = 1'b1;
            3: r = (i == 5);
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (i == 0) drive(1'b1, r, 1'b0, 4'd0, 1'b0);
         else if (i < 5) drive(w[4-i], r, 1'b0, 4'd0, 1'b0);
         else drive(pbit, r, 1'b1, w, pbit ^ (^w));
         busy_cnt += int'(busy);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bc;
      logic [3:0] w;
      logic [3:0] pw;
      logic pb;
      rst_n = 1'b0; serial_p = 1'b0; data_ready = 1'b0; serial_n = 1'b0; ready_n = 1'b1;
      cur_comp = 1'b0; cur_w = 4'd0; cur_pe = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", int'(data_valid), 0);
      chk("rst_data", int'(data_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid_n", int'(valid_n), 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

      // basic frame, then the same frame with a bad parity bit
      send_frame(4'b1010, 1'b0, 1, bc);
      chk("busy_cycles", bc, 5);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      send_frame(4'b1010, 1'b1, 1, bc);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

      // overrun: second frame lands while the first is still pending
      send_frame(4'b1010, 1'b0, 0, bc);
      send_frame(4'b0111, 1'b1, 0, bc);
      chk("held_word", int'(data_out), 10);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      chk("drop_valid", int'(data_valid), 0);
      chk("hold_after_drop", int'(data_out), 10);

      // acceptance and completion on the same edge
      send_frame(4'b1010, 1'b0, 0, bc);
      send_frame(4'b0011, 1'b0, 3, bc);
      chk("swap_valid", int'(data_valid), 1);
      chk("swap_data", int'(data_out), 3);
      chk("swap_overrun", int'(overrun), 0);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

      // asynchronous reset in the middle of a frame with a word pending
      send_frame(4'b1010, 1'b0, 0, bc);
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async_valid", int'(data_valid), 0);
      chk("async_data", int'(data_out), 0);
      chk("async_perr", int'(parity_err), 0);
      chk("async_overrun", int'(overrun), 0);
      chk("async_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_frame(4'b1100, 1'b0, 1, bc);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

      // randomized frames, gaps and backpressure
      for (int f = 0; f < 150; f++) begin
         w  = 4'($urandom_range(0, 15));
         pb = (^w) ^ ($urandom_range(0, 3) == 0);
         send_frame(w, pb, int'($urandom_range(0, 2)), bc);
         for (int g = int'($urandom_range(0, 2)); g > 0; g--)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'd0, 1'b0);
      end
      repeat (3) drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      chk("drain_queue", exp_q.size(), 0);

      // no-parity instance fed with the PISO pattern for 1001
      pw = 4'b1001;
      serial_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 3; i >= 0; i--) begin
         serial_n = pw[i];
         @(posedge clk);
         #1;
         if (i > 0) chk("np_valid_early", int'(valid_n), 0);
      end
      serial_n = 1'b0;
      chk("np_valid", int'(valid_n), 1);
      chk("np_data", int'(data_out_n), 9);
      chk("np_perr", int'(perr_n), 0);
      @(posedge clk);
      #1;
      chk("np_drop", int'(valid_n), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
